// File: rtl/bus_arbiter4_pkg.sv
// Shared definitions for the 4-master system bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] M_IFETCH = 2'd0;
  localparam logic [1:0] M_DATA   = 2'd1;
  localparam logic [1:0] M_VGA    = 2'd2;
  localparam logic [1:0] M_UART   = 2'd3;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// Round-robin winner search: rotate requests so ptr is at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] win,
  output logic       any
);

  logic [7:0] w_dbl;
  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic       w_found;

  assign w_dbl = {req, req};
  assign any   = |req;

  // Rotate and pick the first requester at or after ptr
  always_comb begin
    w_rot   = w_dbl[ptr +: 4];
    w_off   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!w_found && w_rot[i]) begin
        w_off   = i[1:0];
        w_found = 1'b1;
      end
    end
    win = ptr + w_off;
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter/sequencer for the shared 4:1 system bus mux.
// Grants one master at a time, holds until ack (with burst lock),
// inserts one dead turnaround cycle, and forces release on watchdog.
module bus_arbiter4
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CW      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] lock,
  input  logic       ack,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       bus_valid,
  output logic       timeout
);

  localparam logic [CW-1:0] LP_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t        r_state;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_win;
  logic          w_any;
  logic          w_wd_expire;

  // sel doubles as the owner index; it only changes on entry to BUSY
  assign w_wd_expire = (TIMEOUT != 0) && (r_cnt == LP_LAST);

  rr_pick4 u_pick (
    .req (req),
    .ptr (r_ptr),
    .win (w_win),
    .any (w_any)
  );

  // Arbitration FSM with registered grant, select, valid and timeout
  // ptr is advanced on the BUSY->RELEASE edge rather than during RELEASE,
  // so the shared picker already sees owner+1 while in RELEASE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= M_IFETCH;
      r_cnt     <= '0;
      gnt       <= '0;
      sel       <= M_IFETCH;
      bus_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          timeout <= 1'b0;
          r_cnt   <= '0;
          if (w_any) begin
            r_state   <= ST_BUSY;
            gnt       <= onehot4(w_win);
            sel       <= w_win;
            bus_valid <= 1'b1;
          end
        end

        ST_BUSY: begin
          if (ack) begin
            if (lock[sel]) begin
              r_cnt <= '0;
            end else begin
              r_state   <= ST_RELEASE;
              r_ptr     <= sel + 2'd1;
              r_cnt     <= '0;
              gnt       <= '0;
              bus_valid <= 1'b0;
              timeout   <= 1'b0;
            end
          end else if (w_wd_expire) begin
            r_state   <= ST_RELEASE;
            r_ptr     <= sel + 2'd1;
            r_cnt     <= '0;
            gnt       <= '0;
            bus_valid <= 1'b0;
            timeout   <= 1'b1;
          end else if (!req[sel]) begin
            r_state   <= ST_RELEASE;
            r_ptr     <= sel + 2'd1;
            r_cnt     <= '0;
            gnt       <= '0;
            bus_valid <= 1'b0;
            timeout   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_RELEASE: begin
          timeout <= 1'b0;
          r_cnt   <= '0;
          if (w_any) begin
            r_state   <= ST_BUSY;
            gnt       <= onehot4(w_win);
            sel       <= w_win;
            bus_valid <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          gnt       <= '0;
          bus_valid <= 1'b0;
          timeout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Bench for bus_arbiter4: behavioural owner/pointer model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_bus_arbiter4;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic       ack;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       bus_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  bus_arbiter4 #(.TIMEOUT(TMO), .CW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .ack       (ack),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_own  = -1;   // granted master, -1 when nobody holds the bus
  int  m_ptr  = 0;
  int  m_sel  = 0;
  int  m_wait = 0;    // BUSY cycles since grant or last ack
  bit  m_to   = 0;
  bit  m_on   = 0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (!rst_n) begin
      m_own = -1; m_ptr = 0; m_sel = 0; m_wait = 0; m_to = 0; m_on = 1;
    end else if (m_own >= 0) begin
      m_to = 0;
      if (ack) begin
        if (lock[m_own]) m_wait = 0;
        else begin m_ptr = (m_own + 1) % 4; m_own = -1; end
      end else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_ptr = (m_own + 1) % 4; m_own = -1; m_to = 1;
        end else if (!req[m_own]) begin
          m_ptr = (m_own + 1) % 4; m_own = -1;
        end
      end
    end else begin
      m_to = 0;
      w = pick(req, m_ptr);
      if (w >= 0) begin m_own = w; m_sel = w; m_wait = 0; end
    end
    #1;
    if (m_on) begin
      chk("model_gnt", {28'd0, gnt}, (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
      chk("model_sel", {30'd0, sel}, m_sel);
      chk("model_valid", {31'd0, bus_valid}, (m_own >= 0) ? 1 : 0);
      chk("model_timeout", {31'd0, timeout}, {31'd0, m_to});
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic int idx_of(input logic [3:0] g);
    for (int k = 0; k < 4; k++) if (g[k]) return k;
    return -1;
  endfunction

  task automatic wait_gnt(output int gap);
    gap = 0;
    while (gnt == 4'b0 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    if (gnt == 4'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_gnt: got no grant within 40 cycles, expected a grant");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int gap, busy;
    int order [5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b0; req = 4'b1111; lock = 4'b0; ack = 1'b0;

    // reset with all requests up
    repeat (3) @(negedge clk);
    chk("rst_gnt", {28'd0, gnt}, 32'h0);
    chk("rst_sel", {30'd0, sel}, 32'h0);
    chk("rst_valid", {31'd0, bus_valid}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_gnt", {28'd0, gnt}, 32'h1);
    chk("first_sel", {30'd0, sel}, 32'h0);

    // fairness: order 0,1,2,3,0 with one dead cycle between grants
    for (int k = 0; k < 5; k++) begin
      wait_gnt(gap);
      if (k > 0) chk("fair_gap", gap, 1);
      chk("fair_order", idx_of(gnt), order[k]);
      @(negedge clk); ack = 1'b1;
      @(negedge clk); ack = 1'b0;
      if (k == 4) req = 4'b0;
    end

    // burst: master 2 locked across two acks, released on the third
    @(negedge clk);
    req = 4'b0100; lock = 4'b0100;
    wait_gnt(gap);
    chk("burst_sel0", {30'd0, sel}, 32'd2);
    for (int j = 0; j < 3; j++) begin
      lock = (j < 2) ? 4'b0100 : 4'b1011;
      @(negedge clk); ack = 1'b1;
      @(negedge clk); ack = 1'b0;
      if (j < 2) begin
        chk("burst_gnt", {28'd0, gnt}, 32'h4);
        chk("burst_sel", {30'd0, sel}, 32'd2);
      end else begin
        chk("burst_rel", {28'd0, gnt}, 32'h0);
        req = 4'b0;
      end
    end

    // abort: owner 3 drops its request
    @(negedge clk);
    lock = 4'b0; req = 4'b1000;
    wait_gnt(gap);
    chk("abort_gnt", {28'd0, gnt}, 32'h8);
    @(negedge clk); req = 4'b0;
    @(negedge clk);
    chk("abort_rel", {28'd0, gnt}, 32'h0);
    chk("abort_to", {31'd0, timeout}, 32'h0);
    @(negedge clk); req = 4'b1010;
    wait_gnt(gap);
    chk("abort_ptr0", {28'd0, gnt}, 32'h2);

    // watchdog on owner 1, then next grant searched from ptr=2
    req = 4'b0010;
    busy = 1;
    for (int i = 0; i < 20 && gnt != 4'b0; i++) begin
      @(negedge clk);
      if (gnt != 4'b0) busy++;
    end
    chk("wd_busy_cycles", busy, 8);
    chk("wd_pulse", {31'd0, timeout}, 32'h1);
    req = 4'b1011;
    @(negedge clk);
    chk("wd_pulse_end", {31'd0, timeout}, 32'h0);
    chk("wd_ptr2", {28'd0, gnt}, 32'h8);
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0; req = 4'b0;

    // ack while idle is ignored
    @(negedge clk); ack = 1'b1;
    repeat (2) @(negedge clk);
    ack = 1'b0;
    chk("idle_ack", {28'd0, gnt}, 32'h0);

    // ack coincides with watchdog expiry
    req = 4'b0001;
    wait_gnt(gap);
    repeat (7) @(negedge clk);
    chk("coll_still", {28'd0, gnt}, 32'h1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; req = 4'b0;
    chk("coll_rel", {28'd0, gnt}, 32'h0);
    chk("coll_to", {31'd0, timeout}, 32'h0);

    // reset during a transfer by owner 1
    @(negedge clk); req = 4'b0010;
    wait_gnt(gap);
    chk("rstx_gnt", {28'd0, gnt}, 32'h2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstx_drop", {28'd0, gnt}, 32'h0);
    chk("rstx_valid", {31'd0, bus_valid}, 32'h0);
    chk("rstx_to", {31'd0, timeout}, 32'h0);
    rst_n = 1'b1; req = 4'b1001;
    @(negedge clk);
    chk("rstx_ptr0", {28'd0, gnt}, 32'h1);
    req = 4'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
